// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder, LSB first, IDLE/RUN/DONE FSM.
// Computes {cout,sum} = a + b + cin in WIDTH cycles of busy.
module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] bit_mask;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             a_bit;
    logic             b_bit;
    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             last;

    assign accept   = start && (state != RUN);
    assign last     = (cnt == CW'(WIDTH - 1));
    assign bit_mask = WIDTH'(1) << cnt;
    assign a_bit    = |(op_a & bit_mask);
    assign b_bit    = |(op_b & bit_mask);

    fulladder u_fa (
        .A    (a_bit),
        .B    (b_bit),
        .Cin  (carry),
        .S    (fa_s),
        .Cout (fa_c)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // sum is cleared on accept, so OR-ing each new bit in is enough
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
        end else if (state == RUN) begin
            sum   <= sum | bit_mask & {WIDTH{fa_s}};
            carry <= fa_c;
            cnt   <= cnt + CW'(1);
            if (last)
                cout <= fa_c;
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 vectors plus a WIDTH=1
// full-adder truth-table sweep.
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one cycle after the accepting edge; ends in the done cycle.
    task automatic run8(input logic [7:0] es, input logic ec,
                        input string tag);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_busy"}, busy, 1'b1);
            chk({tag, "_nodone"}, done, 1'b0);
            tick();
        end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy_lo"}, busy, 1'b0);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
    endtask

    task automatic op8(input logic [7:0] va, input logic [7:0] vb,
                       input logic vc, input logic [7:0] es,
                       input logic ec, input string tag);
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = 1'($urandom);
        run8(es, ec, tag);
    endtask

    initial begin
        logic [7:0] st_tab;
        logic [7:0] ct_tab;
        logic [2:0] idx;
        int         seen_done;

        st_tab = 8'h96;
        ct_tab = 8'hE8;
        rst    = 1'b1;
        start  = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        cin    = 1'b0;
        start1 = 1'b0;
        a1     = 1'b0;
        b1     = 1'b0;
        cin1   = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_cout", cout, 1'b0);
        chk("rst1_busy", busy1, 1'b0);
        chk("rst1_done", done1, 1'b0);

        // start accepted on the very first edge with rst low
        rst = 1'b0;
        op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
        tick();
        chk("zero_pulse", done, 1'b0);

        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ripple");
        tick();
        chk("ripple_pulse", done, 1'b0);
        chk("ripple_hold_sum", sum, 8'h00);
        chk("ripple_hold_cout", cout, 1'b1);
        tick();

        op8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5_5a");
        tick();
        op8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, "3c_42");
        tick();
        chk("hold_sum", sum, 8'h7E);
        chk("hold_cout", cout, 1'b0);

        // start during RUN must be ignored
        a     = 8'h10;
        b     = 8'h20;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
                cin   = 1'b1;
            end
            chk("ign_busy", busy, 1'b1);
            chk("ign_nodone", done, 1'b0);
            tick();
            start = 1'b0;
        end
        chk("ign_done", done, 1'b1);
        chk("ign_sum", sum, 8'h30);
        chk("ign_cout", cout, 1'b0);
        tick();

        // reset mid-RUN aborts without a done pulse
        a     = 8'hFF;
        b     = 8'h81;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++)
            tick();
        chk("abort_partial_sum", sum, 8'h00);
        chk("abort_busy_pre", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_sum", sum, 8'h00);
        chk("abort_cout", cout, 1'b0);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy)
                seen_done++;
            tick();
        end
        chk("abort_no_done", seen_done, 0);

        // partial-sum check on a non-zero pattern, then abort
        a     = 8'h0F;
        b     = 8'h00;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++)
            tick();
        chk("partial_sum", sum, 8'h0F);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("partial_rst_sum", sum, 8'h00);
        tick();

        // back-to-back: start held on the done cycle
        op8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, "b2b_first");
        a     = 8'h01;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run8(8'h02, 1'b0, "b2b_second");
        tick();
        chk("b2b_idle", done, 1'b0);

        // WIDTH=1 build against the full-adder truth table
        for (int i = 0; i < 8; i++) begin
            idx    = 3'(i);
            cin1   = idx[2];
            a1     = idx[1];
            b1     = idx[0];
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            chk("w1_busy", busy1, 1'b1);
            chk("w1_nodone", done1, 1'b0);
            tick();
            chk("w1_done", done1, 1'b1);
            chk("w1_sum", sum1, st_tab[idx]);
            chk("w1_cout", cout1, ct_tab[idx]);
            tick();
            chk("w1_idle", done1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
